// File: rtl/rand_pkg.sv
// ============================================================================
// Module  : rand_pkg
// Brief   : Shared FSM state encoding and constant helpers for rand_gap_timer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rand_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    // Smallest bit count able to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r_bits;
        int v;
        r_bits = 0;
        v      = value - 1;
        while (v > 0) begin
            r_bits = r_bits + 1;
            v      = v >> 1;
        end
        return r_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_core.sv
// ============================================================================
// Module  : lfsr_core
// Brief   : Left-shifting XNOR LFSR with all-ones lockup escape and load port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic             w_fb;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_ld_fix;

    assign w_fb    = ~^(r_q & TAPS);
    assign w_shift = {r_q[WIDTH-2:0], w_fb};

    // All-ones is the XNOR lockup state; both update paths redirect it to SEED.
    assign w_step_val = (&w_shift) ? SEED : w_shift;
    assign w_ld_fix   = (&ld_val)  ? SEED : ld_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= SEED;
        end else if (ld) begin
            r_q <= w_ld_fix;
        end else if (step) begin
            r_q <= w_step_val;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/rand_gap_timer.sv
// ============================================================================
// Module  : rand_gap_timer
// Brief   : LFSR-randomised spawn timer: LOAD -> COUNT -> FIRE handshake.
//           Define RAND_SEED_LOAD_EN to add the seed_ld/seed_val reseed port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rand_gap_timer
    import rand_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter logic [WIDTH-1:0] SEED     = '0,
    parameter int               GAP_BITS = 4,
    parameter int               MIN_GAP  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             spawn_ack,
`ifdef RAND_SEED_LOAD_EN
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed_val,
`endif
    output logic [WIDTH-1:0] rnd,
    output logic             spawn,
    output logic             busy
);

    localparam int                 c_CNT_W = clog2(MIN_GAP + (1 << GAP_BITS));
    localparam logic [c_CNT_W-1:0] c_MIN   = c_CNT_W'(MIN_GAP);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_gap_cnt;
    logic [c_CNT_W-1:0] w_gap_cnt_nxt;
    logic               w_step;
    logic               w_seed_ld;
    logic [WIDTH-1:0]   w_seed_val;
    logic               r_spawn;
    logic               r_busy;

`ifdef RAND_SEED_LOAD_EN
    assign w_seed_ld  = seed_ld;
    assign w_seed_val = seed_val;
`else
    assign w_seed_ld  = 1'b0;
    assign w_seed_val = '0;
`endif

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .step   (w_step),
        .ld     (w_seed_ld),
        .ld_val (w_seed_val),
        .q      (rnd)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_step        = 1'b0;
        case (r_state)
            LOAD: begin
                if (en) begin
                    // Gap is sampled from the pre-step LFSR value.
                    w_gap_cnt_nxt = c_MIN + {{(c_CNT_W-GAP_BITS){1'b0}}, rnd[GAP_BITS-1:0]};
                    w_step        = 1'b1;
                    w_state_nxt   = COUNT;
                end
            end
            COUNT: begin
                if (en) begin
                    if (r_gap_cnt == c_ONE) begin
                        w_state_nxt = FIRE;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - c_ONE;
                    end
                end
            end
            FIRE: begin
                if (spawn_ack) begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= LOAD;
            r_gap_cnt <= '0;
            r_spawn   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_spawn   <= (w_state_nxt == FIRE);
            r_busy    <= (w_state_nxt == COUNT);
        end
    end

    assign spawn = r_spawn;
    assign busy  = r_busy;

endmodule

`default_nettype wire
